// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, branch
// condition codes and the stage FSM state type.
package ex_pkg;

    // ALU operation encodings (in_alu_op)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    // Branch condition encodings (in_br_funct3)
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Stage FSM: RUN accepts ops, MUL iterates the shift-add multiplier
    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_fwd_unit.sv
// Operand forwarding for one register source. Picks MEM, then WB, then
// register-file data, and flags a load-use hazard when the MEM stage holds
// a load targeting this source.
module ex_fwd_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_addr,
    input  logic [XLEN-1:0]   i_rf_data,
    input  logic              i_used,
    input  logic              i_mem_valid,
    input  logic              i_mem_is_load,
    input  logic [REG_AW-1:0] i_mem_addr,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_data,
    output logic              o_hazard
);

    logic w_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_nz      = (i_addr != '0);
    assign w_mem_hit = i_mem_valid & (i_mem_addr == i_addr) & w_nz;
    assign w_wb_hit  = i_wb_valid  & (i_wb_addr  == i_addr) & w_nz;

    // A load in MEM has no data yet, so it never forwards; it stalls instead
    always_comb begin
        o_data = i_rf_data;
        if (w_mem_hit && !i_mem_is_load) begin
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

    assign o_hazard = i_used & w_mem_hit & i_mem_is_load;

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered RISC-V execute stage: forwarding, load-use detection, ALU,
// branch compare and an EX/MEM output register with valid/ready.
// Optional shift-add multiplier enabled by defining EX_MUL_EN.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [3:0]        in_alu_op,
    input  logic              in_src_imm,
    input  logic              in_is_branch,
    input  logic [2:0]        in_br_funct3,
    input  logic              in_reg_write,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              fwd_mem_valid,
    input  logic              fwd_mem_is_load,
    input  logic [REG_AW-1:0] fwd_mem_addr,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic              fwd_wb_valid,
    input  logic [REG_AW-1:0] fwd_wb_addr,
    input  logic [XLEN-1:0]   fwd_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [XLEN-1:0]   out_store_data,
    output logic [XLEN-1:0]   out_br_target,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write,
    output logic              out_zero,
    output logic              out_br_taken,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              stall_load,
    output logic              busy
);

    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu_res;
    logic [SHW-1:0]  w_shamt;
    logic            w_haz1;
    logic            w_haz2;
    logic            w_rs2_used;
    logic            w_out_free;
    logic            w_accept;
    logic            w_is_mul;
    logic            w_cond;
    logic            w_br_taken;
    logic [XLEN-1:0] w_br_target;

    ex_state_e r_state;
    ex_state_e w_state_nxt;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_store_data;
    logic [XLEN-1:0]   r_br_target;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_reg_write;
    logic              r_zero;
    logic              r_br_taken;
    logic [CTRL_W-1:0] r_ctrl;

    // rs2 is read when it feeds operand B, and by stores (immediate form
    // with no rd write), which need it as store data.
    assign w_rs2_used = !in_src_imm | !in_reg_write;

    ex_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .i_addr        (in_rs1_addr),
        .i_rf_data     (in_rs1_data),
        .i_used        (1'b1),
        .i_mem_valid   (fwd_mem_valid),
        .i_mem_is_load (fwd_mem_is_load),
        .i_mem_addr    (fwd_mem_addr),
        .i_mem_data    (fwd_mem_data),
        .i_wb_valid    (fwd_wb_valid),
        .i_wb_addr     (fwd_wb_addr),
        .i_wb_data     (fwd_wb_data),
        .o_data        (w_rs1),
        .o_hazard      (w_haz1)
    );

    ex_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .i_addr        (in_rs2_addr),
        .i_rf_data     (in_rs2_data),
        .i_used        (w_rs2_used),
        .i_mem_valid   (fwd_mem_valid),
        .i_mem_is_load (fwd_mem_is_load),
        .i_mem_addr    (fwd_mem_addr),
        .i_mem_data    (fwd_mem_data),
        .i_wb_valid    (fwd_wb_valid),
        .i_wb_addr     (fwd_wb_addr),
        .i_wb_data     (fwd_wb_data),
        .o_data        (w_rs2),
        .o_hazard      (w_haz2)
    );

    // Hazard only matters while an op is actually presented
    assign stall_load = in_valid & (w_haz1 | w_haz2);
    assign w_out_free = !r_out_valid | out_ready;
    assign in_ready   = (r_state == ST_RUN) & !stall_load & w_out_free & !flush;
    assign w_accept   = in_valid & in_ready;

    assign w_op_b  = in_src_imm ? in_imm : w_rs2;
    assign w_shamt = w_op_b[SHW-1:0];

    // ALU; MUL and undefined codes give 0 here (MUL result comes from the iterator)
    always_comb begin
        w_alu_res = '0;
        case (in_alu_op)
            ALU_AND:  w_alu_res = w_rs1 & w_op_b;
            ALU_OR:   w_alu_res = w_rs1 | w_op_b;
            ALU_ADD:  w_alu_res = w_rs1 + w_op_b;
            ALU_SUB:  w_alu_res = w_rs1 - w_op_b;
            ALU_XOR:  w_alu_res = w_rs1 ^ w_op_b;
            ALU_SLL:  w_alu_res = w_rs1 << w_shamt;
            ALU_SRL:  w_alu_res = w_rs1 >> w_shamt;
            ALU_SRA:  w_alu_res = $signed(w_rs1) >>> w_shamt;
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_rs1) < $signed(w_op_b))};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (w_rs1 < w_op_b)};
            default:  w_alu_res = '0;
        endcase
    end

    // Branch compare always works on the two register sources
    always_comb begin
        w_cond = 1'b0;
        case (in_br_funct3)
            BR_EQ:   w_cond = (w_rs1 == w_rs2);
            BR_NE:   w_cond = (w_rs1 != w_rs2);
            BR_LT:   w_cond = ($signed(w_rs1) < $signed(w_rs2));
            BR_GE:   w_cond = ($signed(w_rs1) >= $signed(w_rs2));
            BR_LTU:  w_cond = (w_rs1 < w_rs2);
            BR_GEU:  w_cond = (w_rs1 >= w_rs2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_br_taken  = in_is_branch & w_cond;
    assign w_br_target = in_pc + in_imm;

`ifdef EX_MUL_EN
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_p_store;
    logic [XLEN-1:0]   r_p_target;
    logic [REG_AW-1:0] r_p_rd;
    logic              r_p_reg_write;
    logic              r_p_taken;
    logic [CTRL_W-1:0] r_p_ctrl;
    logic              w_iter_done;
    logic              w_mul_done;

    assign w_is_mul    = (in_alu_op == ALU_MUL);
    assign w_iter_done = (r_cnt == CNT_W'(XLEN));
    assign w_mul_done  = (r_state == ST_MUL) & w_iter_done & w_out_free;
    assign busy        = (r_state == ST_MUL) & !w_iter_done;

    // Shift-add multiplier: one multiplier bit per cycle, payload latched at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_p_store     <= '0;
            r_p_target    <= '0;
            r_p_rd        <= '0;
            r_p_reg_write <= 1'b0;
            r_p_taken     <= 1'b0;
            r_p_ctrl      <= '0;
        end else if (flush) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand       <= w_rs1;
            r_mplier      <= w_op_b;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_p_store     <= w_rs2;
            r_p_target    <= w_br_target;
            r_p_rd        <= in_rd_addr;
            r_p_reg_write <= in_reg_write;
            r_p_taken     <= w_br_taken;
            r_p_ctrl      <= in_ctrl;
        end else if (w_mul_done) begin
            r_cnt <= '0;
        end else if (r_state == ST_MUL && !w_iter_done) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Next state: enter MUL on a multiply accept, leave when the result is stored
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (w_accept && w_is_mul) w_state_nxt = ST_MUL;
                ST_MUL:  if (w_mul_done) w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end
`else
    assign w_is_mul = 1'b0;
    assign busy     = 1'b0;

    // Without the multiplier the stage never leaves RUN
    always_comb begin
        w_state_nxt = ST_RUN;
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // EX/MEM output register: flush > new load > drain on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_br_target  <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_zero       <= 1'b0;
            r_br_taken   <= 1'b0;
            r_ctrl       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid  <= 1'b1;
            r_alu_result <= w_alu_res;
            r_zero       <= (w_alu_res == '0);
            r_store_data <= w_rs2;
            r_br_target  <= w_br_target;
            r_rd_addr    <= in_rd_addr;
            r_reg_write  <= in_reg_write;
            r_br_taken   <= w_br_taken;
            r_ctrl       <= in_ctrl;
`ifdef EX_MUL_EN
        end else if (w_mul_done) begin
            r_out_valid  <= 1'b1;
            r_alu_result <= r_acc;
            r_zero       <= (r_acc == '0);
            r_store_data <= r_p_store;
            r_br_target  <= r_p_target;
            r_rd_addr    <= r_p_rd;
            r_reg_write  <= r_p_reg_write;
            r_br_taken   <= r_p_taken;
            r_ctrl       <= r_p_ctrl;
`endif
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_alu_result = r_alu_result;
    assign out_store_data = r_store_data;
    assign out_br_target  = r_br_target;
    assign out_rd_addr    = r_rd_addr;
    assign out_reg_write  = r_reg_write;
    assign out_zero       = r_zero;
    assign out_br_taken   = r_br_taken;
    assign out_ctrl       = r_ctrl;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: vector table for ALU/branch plus
// hand sequences for forwarding, load-use, backpressure, flush, reset, MUL.
module tb_ex_stage_pipe;
    import ex_pkg::*;

    localparam int XLEN = 32, REG_AW = 5, CTRL_W = 8;

    logic clk = 1'b0, rst, flush, in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [REG_AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0] in_alu_op;
    logic in_src_imm, in_is_branch, in_reg_write;
    logic [2:0] in_br_funct3;
    logic [CTRL_W-1:0] in_ctrl;
    logic fwd_mem_valid, fwd_mem_is_load, fwd_wb_valid;
    logic [REG_AW-1:0] fwd_mem_addr, fwd_wb_addr;
    logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
    logic out_valid, out_ready;
    logic [XLEN-1:0] out_alu_result, out_store_data, out_br_target;
    logic [REG_AW-1:0] out_rd_addr;
    logic out_reg_write, out_zero, out_br_taken, stall_load, busy;
    logic [CTRL_W-1:0] out_ctrl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_alu_op(in_alu_op), .in_src_imm(in_src_imm), .in_is_branch(in_is_branch),
        .in_br_funct3(in_br_funct3), .in_reg_write(in_reg_write), .in_ctrl(in_ctrl),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_is_load(fwd_mem_is_load),
        .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_result(out_alu_result),
        .out_store_data(out_store_data), .out_br_target(out_br_target),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .out_zero(out_zero),
        .out_br_taken(out_br_taken), .out_ctrl(out_ctrl), .stall_load(stall_load), .busy(busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        si, br;
        logic [2:0]  f3;
        logic [31:0] pc, res;
        logic        z, tk;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                logic si, logic br, logic [2:0] f3, logic [31:0] pc,
                                logic [31:0] res, logic z, logic tk, logic [31:0] tgt);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.imm = imm; v.si = si; v.br = br; v.f3 = f3;
        v.pc = pc; v.res = res; v.z = z; v.tk = tk; v.tgt = tgt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        flush = 0; in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_alu_op = 0; in_src_imm = 0;
        in_is_branch = 0; in_br_funct3 = 0; in_reg_write = 0; in_ctrl = 0;
        fwd_mem_valid = 0; fwd_mem_is_load = 0; fwd_mem_addr = 0; fwd_mem_data = 0;
        fwd_wb_valid = 0; fwd_wb_addr = 0; fwd_wb_data = 0; out_ready = 1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic si, input logic br,
                            input logic [2:0] f3, input logic [31:0] pc);
        in_valid = 1; in_alu_op = op; in_rs1_data = a; in_rs2_data = b; in_imm = imm;
        in_src_imm = si; in_is_branch = br; in_br_funct3 = f3; in_pc = pc;
        in_rs1_addr = 1; in_rs2_addr = 2; in_rd_addr = 3; in_reg_write = !br; in_ctrl = 8'h5A;
    endtask

    initial begin
        int cnt;
        clr_in();
        rst = 1;
        step(); step();
        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_alu_result, 0);
        chk("rst_flags", {out_zero, out_br_taken, out_reg_write}, 0);
        chk("rst_stall", stall_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 0;
        step();

        // ALU / branch vector table, applied back to back
        vecs.push_back(mk(ALU_AND,  32'hF0F0, 32'h0FF0, 4, 0, 0, 0, 32'h1000, 32'h00F0, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_OR,   32'hF000, 32'h000F, 4, 0, 0, 0, 32'h1000, 32'hF00F, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_ADD,  32'hFFFF_FFFF, 1, 4, 0, 0, 0, 32'h1000, 0, 1, 0, 32'h1004));
        vecs.push_back(mk(ALU_ADD,  32'h10, 32'h55, 32'h20, 1, 0, 0, 32'h1000, 32'h30, 0, 0, 32'h1020));
        vecs.push_back(mk(ALU_SUB,  5, 5, 4, 0, 0, 0, 32'h1000, 0, 1, 0, 32'h1004));
        vecs.push_back(mk(ALU_SUB,  3, 5, 4, 0, 0, 0, 32'h1000, 32'hFFFF_FFFE, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0, 4, 0, 0, 0, 32'h1000, 32'hF0F0_F0F0, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_SLL,  1, 32'h21, 4, 0, 0, 0, 32'h1000, 2, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_SLL,  1, 31, 4, 0, 0, 0, 32'h1000, 32'h8000_0000, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_SRL,  32'h8000_0000, 4, 4, 0, 0, 0, 32'h1000, 32'h0800_0000, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_SRA,  32'h8000_0000, 4, 4, 0, 0, 0, 32'h1000, 32'hF800_0000, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_SLT,  32'hFFFF_FFFF, 1, 4, 0, 0, 0, 32'h1000, 1, 0, 0, 32'h1004));
        vecs.push_back(mk(ALU_SLT,  1, 32'hFFFF_FFFF, 4, 0, 0, 0, 32'h1000, 0, 1, 0, 32'h1004));
        vecs.push_back(mk(ALU_SLTU, 1, 32'hFFFF_FFFF, 4, 0, 0, 0, 32'h1000, 1, 0, 0, 32'h1004));
        vecs.push_back(mk(4'b1111,  7, 9, 4, 0, 0, 0, 32'h1000, 0, 1, 0, 32'h1004));
        vecs.push_back(mk(ALU_SUB,  32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 0, 1, BR_LT,  32'h100, 32'hFFFF_FFFE, 0, 1, 32'hF0));
        vecs.push_back(mk(ALU_SUB,  32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 0, 1, BR_GEU, 32'h100, 32'hFFFF_FFFE, 0, 1, 32'hF0));
        vecs.push_back(mk(ALU_SUB,  32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 0, 1, BR_GE,  32'h100, 32'hFFFF_FFFE, 0, 0, 32'hF0));
        vecs.push_back(mk(ALU_SUB,  32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 0, 1, BR_LTU, 32'h100, 32'hFFFF_FFFE, 0, 0, 32'hF0));
        vecs.push_back(mk(ALU_SUB,  5, 5, 32'hFFFF_FFF0, 0, 1, BR_EQ,  32'h100, 0, 1, 1, 32'hF0));
        vecs.push_back(mk(ALU_SUB,  5, 5, 32'hFFFF_FFF0, 0, 1, BR_NE,  32'h100, 0, 1, 0, 32'hF0));
        vecs.push_back(mk(ALU_SUB,  5, 5, 32'hFFFF_FFF0, 0, 1, 3'b010, 32'h100, 0, 1, 0, 32'hF0));
        vecs.push_back(mk(ALU_SUB,  5, 5, 32'hFFFF_FFF0, 0, 0, BR_EQ,  32'h100, 0, 1, 0, 32'hF0));
        foreach (vecs[i]) begin
            drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].si,
                     vecs[i].br, vecs[i].f3, vecs[i].pc);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), out_alu_result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), out_zero, vecs[i].z);
            chk($sformatf("vec%0d_taken", i), out_br_taken, vecs[i].tk);
            chk($sformatf("vec%0d_target", i), out_br_target, vecs[i].tgt);
            chk($sformatf("vec%0d_store", i), out_store_data, vecs[i].b);
            chk($sformatf("vec%0d_rd_ctrl", i), {out_reg_write, out_rd_addr, out_ctrl},
                {!vecs[i].br, 5'd3, 8'h5A});
        end
        clr_in();
        step();
        chk("drain_valid", out_valid, 0);

        // forwarding priority
        in_valid = 1; in_alu_op = ALU_ADD; in_rs1_addr = 5; in_rs1_data = 32'hDEAD;
        in_src_imm = 1; in_imm = 3; in_rs2_addr = 6; in_reg_write = 1;
        fwd_mem_valid = 1; fwd_mem_addr = 5; fwd_mem_data = 32'h10;
        fwd_wb_valid = 1; fwd_wb_addr = 5; fwd_wb_data = 32'h99;
        #1;
        chk("fwd_stall", stall_load, 0);
        step();
        chk("fwd_mem_result", out_alu_result, 32'h13);
        chk("fwd_mem_zero", out_zero, 0);
        fwd_mem_valid = 0;
        step();
        chk("fwd_wb_result", out_alu_result, 32'h9C);
        in_rs1_addr = 0; in_rs1_data = 7; fwd_mem_valid = 1; fwd_mem_addr = 0;
        fwd_wb_addr = 6; fwd_wb_data = 32'h66;
        step();
        chk("fwd_x0_result", out_alu_result, 32'hA);
        chk("fwd_rs2_store", out_store_data, 32'h66);
        clr_in();
        step();

        // load-use hazard
        in_valid = 1; in_alu_op = ALU_ADD; in_rs1_addr = 1; in_rs1_data = 1;
        in_rs2_addr = 7; in_rs2_data = 32'hBAD; in_reg_write = 1;
        fwd_mem_valid = 1; fwd_mem_is_load = 1; fwd_mem_addr = 7;
        #1;
        chk("lu_stall", stall_load, 1);
        chk("lu_in_ready", in_ready, 0);
        step();
        chk("lu_no_accept", out_valid, 0);
        fwd_mem_valid = 0; fwd_mem_is_load = 0;
        fwd_wb_valid = 1; fwd_wb_addr = 7; fwd_wb_data = 32'h20;
        #1;
        chk("lu_clear_stall", stall_load, 0);
        chk("lu_clear_ready", in_ready, 1);
        step();
        chk("lu_accept_valid", out_valid, 1);
        chk("lu_accept_result", out_alu_result, 32'h21);
        fwd_wb_valid = 0; fwd_mem_valid = 1; fwd_mem_is_load = 1;
        in_src_imm = 1; in_imm = 4;
        #1;
        chk("lu_imm_no_stall", stall_load, 0);
        step();
        chk("lu_imm_result", out_alu_result, 5);
        in_reg_write = 0;
        #1;
        chk("lu_store_stall", stall_load, 1);
        in_reg_write = 1; in_rs1_addr = 7; in_rs2_addr = 2;
        #1;
        chk("lu_rs1_stall", stall_load, 1);
        in_rs1_addr = 0; in_rs2_addr = 0; fwd_mem_addr = 0;
        #1;
        chk("lu_x0_no_stall", stall_load, 0);
        clr_in();
        step();

        // backpressure
        out_ready = 0;
        drive_op(ALU_ADD, 1, 2, 0, 0, 0, 0, 0);
        step();
        chk("bp_first_valid", out_valid, 1);
        drive_op(ALU_ADD, 10, 20, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready_low", in_ready, 0);
            step();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", out_alu_result, 3);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", out_alu_result, 32'h1E);
        clr_in();
        step();
        chk("bp_drain", out_valid, 0);

        // flush
        out_ready = 0;
        drive_op(ALU_ADD, 1, 1, 0, 0, 0, 0, 0);
        step();
        chk("fl_loaded", out_valid, 1);
        drive_op(ALU_ADD, 2, 2, 0, 0, 0, 0, 0);
        out_ready = 1; flush = 1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        step();
        chk("fl_valid_cleared", out_valid, 0);
        clr_in();
        step();
        chk("fl_no_accept", out_valid, 0);

        // synchronous reset clears a held result
        out_ready = 0;
        drive_op(ALU_OR, 32'hF, 32'hF0, 0, 0, 0, 0, 0);
        step();
        chk("rr_loaded", out_alu_result, 32'hFF);
        in_valid = 0; rst = 1;
        step();
        chk("rr_valid", out_valid, 0);
        chk("rr_result", out_alu_result, 0);
        chk("rr_ctrl", out_ctrl, 0);
        rst = 0; out_ready = 1;
        step();

`ifdef EX_MUL_EN
        // multi-cycle multiply
        drive_op(ALU_MUL, 32'h1234, 32'h10, 0, 0, 0, 0, 0);
        #1;
        chk("mul_accept_ready", in_ready, 1);
        step();
        clr_in();
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (cnt == 1) chk("mul_busy_in_ready", in_ready, 0);
            step();
        end
        chk("mul_busy_cycles", cnt, 32);
        chk("mul_not_yet_valid", out_valid, 0);
        step();
        chk("mul_valid", out_valid, 1);
        chk("mul_result", out_alu_result, 32'h12340);
        chk("mul_zero", out_zero, 0);
        chk("mul_rd", out_rd_addr, 3);
        step();
        // flush at iteration 10
        drive_op(ALU_MUL, 32'h1234, 32'h10, 0, 0, 0, 0, 0);
        step();
        clr_in();
        repeat (10) step();
        chk("mulfl_busy_before", busy, 1);
        flush = 1;
        step();
        flush = 0;
        chk("mulfl_busy", busy, 0);
        chk("mulfl_valid", out_valid, 0);
        repeat (30) step();
        chk("mulfl_no_result", out_valid, 0);
        chk("mulfl_in_ready", in_ready, 1);
        // reset mid-multiply
        drive_op(ALU_MUL, 3, 5, 0, 0, 0, 0, 0);
        step();
        clr_in();
        repeat (5) step();
        rst = 1;
        step();
        rst = 0;
        chk("mulrst_busy", busy, 0);
        chk("mulrst_valid", out_valid, 0);
        chk("mulrst_ready", in_ready, 1);
`else
        // op 1000 without the multiplier completes in one cycle with 0
        drive_op(ALU_MUL, 7, 3, 0, 0, 0, 0, 0);
        #1;
        chk("nomul_ready", in_ready, 1);
        step();
        chk("nomul_valid", out_valid, 1);
        chk("nomul_result", out_alu_result, 0);
        chk("nomul_zero", out_zero, 1);
        chk("nomul_busy", busy, 0);
        clr_in();
        step();
        chk("nomul_drain", out_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, registered execute stage for the RISC-V pipeline; successor to the combinational execute block. It sits between the ID/EX and EX/MEM boundaries. It takes decoded operands and forwards from MEM and WB, detects load-use hazards, and runs the ALU and branch compare. Results are held in an EX/MEM output register behind a valid/ready handshake. An optional multi-cycle multiplier is available.

## Interface
- XLEN, 32: datapath width
- REG_AW, 5: register address width
- CTRL_W, 8: width of pass-through memory/writeback control bundle
- clk  in  1  pipeline clock; one clock only
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill in-flight op and output register
- in_valid / in_ready  in / out  1  ID/EX handshake
- in_pc, in_rs1_data, in_rs2_data, in_imm  in  XLEN  operands
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  REG_AW  register addresses
- in_alu_op  in  4  ALU operation
- in_src_imm  in  1  operand B = in_imm when 1, else forwarded rs2
- in_is_branch  in  1  conditional branch
- in_br_funct3  in  3  branch condition
- in_reg_write  in  1  writes rd
- in_ctrl  in  CTRL_W  passed through to out_ctrl
- fwd_mem_valid, fwd_mem_is_load  in  1  EX/MEM stage forward qualifiers
- fwd_mem_addr / fwd_mem_data  in  REG_AW / XLEN  EX/MEM forward source
- fwd_wb_valid  in  1  MEM/WB stage forward qualifier
- fwd_wb_addr / fwd_wb_data  in  REG_AW / XLEN  MEM/WB forward source
- out_valid / out_ready  out / in  1  EX/MEM handshake
- out_alu_result, out_store_data, out_br_target  out  XLEN  results
- out_rd_addr  out  REG_AW  destination register
- out_reg_write, out_zero, out_br_taken  out  1  flags
- out_ctrl  out  CTRL_W  control bundle
- stall_load  out  1  load-use hazard present this cycle
- busy  out  1  multiplier iterating

## Operation
- **Forwarding**, per source:
  - Use MEM data if fwd_mem_valid, addr match, addr≠0 and not fwd_mem_is_load.
  - Else use WB data if fwd_wb_valid, addr match, addr≠0.
  - Else use the register-file value. MEM has priority over WB.
- **Load-use**:
  - Condition: fwd_mem_valid & fwd_mem_is_load & addr match on a used source (rs2 only if !in_src_imm or store) & addr≠0.
  - Effect: stall_load=1, in_ready=0, no accept.
- **Accept**: in_valid & in_ready.
  - in_ready = state RUN & !stall_load & (!out_valid | out_ready) & !flush.
- **ALU ops**:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR.
  - 0100 SLL, 0101 SRL, 0111 SRA; shift amount is B[$clog2(XLEN)-1:0].
  - 1001 SLT (signed), 1010 SLTU; result is zero-extended 0/1.
  - 1000 MUL (low XLEN bits).
  - Other codes give result 0.
- Arithmetic wraps modulo 2^XLEN.
- out_zero = (result == 0), computed from the result being registered, not a previous one.
- **Branch**:
  - funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes are not taken.
  - out_br_taken = in_is_branch & condition.
  - out_br_target = in_pc + in_imm (wraps).
- out_store_data = forwarded rs2, independent of in_src_imm.
- **FSM**, states RUN, MUL:
  - RUN→MUL on accept of op 1000 (EX_MUL_EN only).
  - MUL→RUN when the iteration count reaches XLEN and the output register is loaded.
  - Any state→RUN on flush.

## Timing
- Reset: every output 0 (out_valid, out_* data/flags, stall_load, busy); in_ready follows its equation (1 after reset); FSM RUN; iteration counter 0.
- Single-cycle ops: accepted at edge N, out_valid=1 after edge N.
- out_valid holds with stable payload while out_ready=0; it clears on a handshake unless a new op loads the same edge (back-to-back throughput of 1 per cycle).
- MUL:
  - Operands are latched at accept; busy=1 for XLEN cycles (shift-add, one bit per cycle).
  - Result is loaded at the next edge where the output register is free; total latency XLEN+1 minimum.
- flush:
  - Takes priority over accept, handshake and MUL completion.
  - Next edge: out_valid=0, busy=0, FSM RUN.
- rst mid-MUL aborts identically to flush, and also clears outputs.
- stall_load is combinational, same cycle as the hazard.

## Configuration
- Macro EX_MUL_EN.
- Defined: multiplier datapath, MUL state and busy are present.
- Undefined: op 1000 completes in 1 cycle with result 0; FSM stays RUN; busy is tied 0.

## Structure
- Shared package ex_pkg holds:
  - ALU op localparams (ALU_AND … ALU_MUL)
  - branch funct3 constants
  - FSM state typedef
- Sub-module ex_fwd_unit: one instance per source; combinational operand select plus hazard match.
- ALU, branch unit, FSM and output register live in ex_stage_pipe.

## Test plan
- ADD forwarding: rs1=x5 with fwd_mem addr 5 data 0x10 and fwd_wb addr 5 data 0x99; rs2 imm 3 -> out_alu_result=0x13 one cycle after accept, out_zero=0.
- Load-use: fwd_mem_is_load=1 addr 7, in rs2_addr=7, !in_src_imm -> stall_load=1, in_ready=0; next cycle hazard gone -> accept.
- SUB and zero flag: 5-5 -> result 0, out_zero=1. SRA: 0x8000_0000 by 4 -> 0xF800_0000. SLTU: 1 vs 0xFFFF_FFFF -> 1.
- Branch BLT: -1 vs 1, pc 0x100, imm 0xFFFF_FFF0 -> out_br_taken=1, out_br_target=0xF0. BGEU on same operands -> taken.
- Backpressure: out_ready=0 for 3 cycles -> payload stable, in_ready=0; release -> next op loads the same edge.
- MUL (EX_MUL_EN): 0x1234×0x10 -> busy 32 cycles, result 0x12340. Flush at iteration 10 -> busy=0, out_valid=0 the next cycle.
